// File: rtl/i2s_rx_if.sv
// Register bus for i2s_rx. write is a single-cycle strobe qualified by address;
// readdata is a combinational function of address, with no ready or wait states.
interface i2s_rx_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output write, output writedata, input readdata);
    modport slave  (input address, input write, input writedata, output readdata);
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes codec SCLK/LRCLK/Din into CLK, assembles left/right
// words into stereo pairs, queues them in a FIFO and exposes them on a 4-register bus.
module i2s_rx #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCLK,
    input  logic       LRCLK,
    input  logic       Din,
    i2s_rx_if.slave    bus,
    output logic       sample_valid,
    output logic [1:0] state_dbg
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int BCW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Synchronizer bits are ordered {sclk, lrclk, din}.
    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic               sclk_prev_q, sclk_prev_d;
    logic               lr_prev_q, lr_prev_d;
    logic               lr_seen_q, lr_seen_d;
    state_t             state_q, state_d;
    logic               chan_q, chan_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   left_hold_q, left_hold_d;
    logic               left_ok_q, left_ok_d;
    logic [2*WIDTH-1:0] pair_q, pair_d;
    logic               push_pend_q, push_pend_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;

    logic               sclk_s, lr_s, din_s;
    logic               bit_event, lr_change;
    logic [WIDTH-1:0]   word;
    logic               word_done, ferr_set;
    logic               pop, accept, empty, full, wr_status;
    logic [2*WIDTH-1:0] head;
    logic               unused_wdata;

    assign sclk_s    = sync2_q[2];
    assign lr_s      = sync2_q[1];
    assign din_s     = sync2_q[0];
    assign bit_event = sclk_s & ~sclk_prev_q;
    // No LRCLK change can be claimed until one bit event has recorded a reference level.
    assign lr_change = lr_seen_q & (lr_s != lr_prev_q);
    assign word      = {shift_q[WIDTH-2:0], din_s};

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNTW'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign pop       = bus.write & (bus.address == 2'd3) & ~empty;
    assign accept    = push_pend_q & (~full | pop);
    assign wr_status = bus.write & (bus.address == 2'd0);

    assign sample_valid = accept;
    assign state_dbg    = state_q;
    assign unused_wdata = ^bus.writedata[29:0];

    always_comb begin
        sync1_d     = {SCLK, LRCLK, Din};
        sync2_d     = sync1_q;
        sclk_prev_d = sclk_s;
        lr_prev_d   = lr_prev_q;
        lr_seen_d   = lr_seen_q;
        state_d     = state_q;
        chan_d      = chan_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        pair_d      = pair_q;
        push_pend_d = 1'b0;
        word_done   = 1'b0;
        ferr_set    = 1'b0;

        if (bit_event) begin
            lr_prev_d = lr_s;
            lr_seen_d = 1'b1;
            if (lr_change) begin
                // A word channel boundary mid-capture abandons the partial word.
                ferr_set = (state_q == SKIP) || (state_q == SHIFT);
                state_d  = SKIP;
                chan_d   = lr_s;
            end else begin
                case (state_q)
                    SKIP: begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end
                    SHIFT: begin
                        shift_d   = word;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                            state_d   = WAIT;
                            word_done = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (word_done) begin
            if (!chan_q) begin
                left_hold_d = word;
                left_ok_d   = 1'b1;
            end else if (left_ok_q) begin
                pair_d      = {left_hold_q, word};
                push_pend_d = 1'b1;
                left_ok_d   = 1'b0;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // When full, the popped head slot is the one the accepted push overwrites.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (accept) begin
            mem_d[wr_ptr_q] = pair_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: ;
        endcase
        overrun_d   = (push_pend_q & ~accept) |
                      (overrun_q & ~(wr_status & bus.writedata[31]));
        frame_err_d = ferr_set | (frame_err_q & ~(wr_status & bus.writedata[30]));
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata = {overrun_q, frame_err_q, 20'b0, empty, full, 8'(count_q)};
            2'd1: if (!empty) bus.readdata = 32'(head[2*WIDTH-1:WIDTH]) << (32 - WIDTH);
            2'd2: if (!empty) bus.readdata = 32'(head[WIDTH-1:0]) << (32 - WIDTH);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            lr_seen_q   <= 1'b0;
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            pair_q      <= '0;
            push_pend_q <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sclk_prev_q <= sclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            lr_seen_q   <= lr_seen_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            pair_q      <= pair_d;
            push_pend_q <= push_pend_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames at SCLK = CLK/16 and checks pulses, status
// and FIFO contents against a queue-based reference model.
module tb_i2s_rx;
    localparam int WIDTH    = 24;
    localparam int DEPTH    = 4;
    localparam int HALF     = 32;  // SCLK slots per channel
    localparam int MSB_SLOT = 2;   // change event, one discarded slot, then MSB
    localparam int SCLK_HP  = 80;  // 8 CLK periods

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SCLK = 1'b0;
    logic       LRCLK = 1'b1;
    logic       Din = 1'b0;
    logic       sample_valid;
    logic [1:0] state_dbg;

    i2s_rx_if bus_if ();

    i2s_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .Din          (Din),
        .bus          (bus_if),
        .sample_valid (sample_valid),
        .state_dbg    (state_dbg)
    );

    always #5 CLK = ~CLK;

    logic [2*WIDTH-1:0] exp_q [$];     // pairs expected to raise sample_valid
    logic [2*WIDTH-1:0] mdl_fifo [$];  // reference FIFO contents
    bit                 exp_ovr;
    bit                 exp_ferr;
    int                 n_checks = 0;
    int                 n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every sample_valid pulse must match a predicted accepted push.
    always @(negedge CLK) begin
        if (!RESET && sample_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample_valid: got unexpected pulse, expected none");
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        bus_if.address = a;
        @(negedge CLK);
        d = bus_if.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(posedge CLK); #1;
        bus_if.write     = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = mdl_fifo.size();
        return {exp_ovr, exp_ferr, 20'b0, n == 0, n == DEPTH, 8'(n)};
    endfunction

    task automatic model_reset();
        mdl_fifo.delete();
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic model_push(input logic [2*WIDTH-1:0] pair, input bit pop_same);
        if (pop_same && mdl_fifo.size() > 0) void'(mdl_fifo.pop_front());
        if (mdl_fifo.size() < DEPTH) begin
            mdl_fifo.push_back(pair);
            exp_q.push_back(pair);
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        logic [31:0] el;
        logic [31:0] er;
        el = 32'h0;
        er = 32'h0;
        if (mdl_fifo.size() > 0) begin
            el = {mdl_fifo[0][47:24], 8'h00};
            er = {mdl_fifo[0][23:0], 8'h00};
        end
        rd(2'd0, d); check({tag, "_status"}, d, exp_status());
        rd(2'd1, d); check({tag, "_left"}, d, el);
        rd(2'd2, d); check({tag, "_right"}, d, er);
    endtask

    task automatic pop_check(input string tag);
        check_regs(tag);
        wr(2'd3, 32'h0);
        if (mdl_fifo.size() > 0) void'(mdl_fifo.pop_front());
    endtask

    task automatic drain(input string tag);
        while (mdl_fifo.size() > 0) pop_check(tag);
        check_regs({tag, "_drained"});
    endtask

    task automatic send_half(input bit ch, input logic [WIDTH-1:0] w, input int nslots);
        for (int i = 0; i < nslots; i++) begin
            SCLK  = 1'b0;
            LRCLK = ch;
            if (i >= MSB_SLOT && i < MSB_SLOT + WIDTH) Din = w[WIDTH-1-(i-MSB_SLOT)];
            else Din = 1'($urandom);
            #SCLK_HP;
            SCLK = 1'b1;
            #SCLK_HP;
        end
    endtask

    task automatic send_frame(input logic [2*WIDTH-1:0] pair);
        send_half(1'b0, pair[47:24], HALF);
        send_half(1'b1, pair[23:0], HALF);
    endtask

    function automatic logic [2*WIDTH-1:0] rand_pair();
        return {24'($urandom), 24'($urandom)};
    endfunction

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [31:0]        d;
        logic [2*WIDTH-1:0] p;
        logic [2*WIDTH-1:0] f [5];

        bus_if.address   = 2'd0;
        bus_if.write     = 1'b0;
        bus_if.writedata = 32'h0;
        model_reset();
        repeat (5) @(posedge CLK);
        #1 RESET = 1'b0;

        // Reset state
        check("reset_state", 32'(state_dbg), 32'd0);
        rd(2'd0, d); check("reset_status_lit", d, 32'h0000_0200);
        check_regs("reset");
        rd(2'd3, d); check("reg3_zero", d, 32'h0);
        send_half(1'b1, 24'h0, 4);

        // Single known frame
        p = {24'hABCDEF, 24'h123456};
        model_push(p, 1'b0);
        send_frame(p);
        check("basic_pulse_pending", 32'(exp_q.size()), 0);
        rd(2'd1, d); check("basic_left_lit", d, 32'hABCD_EF00);
        rd(2'd2, d); check("basic_right_lit", d, 32'h1234_5600);
        check_regs("basic");
        drain("basic");

        // Overrun: five frames, no pops
        for (int i = 0; i < 5; i++) begin
            f[i] = rand_pair();
            model_push(f[i], 1'b0);
            send_frame(f[i]);
        end
        check("ovr_pulse_pending", 32'(exp_q.size()), 0);
        rd(2'd0, d); check("ovr_status_lit", d, 32'h8000_0104);
        check_regs("ovr");
        wr(2'd0, 32'h8000_0000);
        exp_ovr = 1'b0;
        rd(2'd0, d); check("ovr_clear_lit", d, 32'h0000_0104);

        // Full FIFO: pop in the same cycle as the right-word push
        p = rand_pair();
        model_push(p, 1'b1);
        fork
            send_frame(p);
            begin : popper
                int ph;
                ph = 0;
                for (int c = 0; c < 3000 && ph < 4; c++) begin
                    @(posedge CLK); #1;
                    case (ph)
                        0: if (LRCLK == 1'b0) ph = 1;
                        1: if (LRCLK == 1'b1) ph = 2;
                        2: if (state_dbg == 2'd2) ph = 3;
                        default: if (state_dbg == 2'd3) begin
                            bus_if.address = 2'd3;
                            bus_if.write   = 1'b1;
                            @(posedge CLK); #1;
                            bus_if.write   = 1'b0;
                            ph = 4;
                        end
                    endcase
                end
                check("pushpop_sync", 32'(ph), 32'd4);
            end
        join
        check("pushpop_pulse_pending", 32'(exp_q.size()), 0);
        rd(2'd0, d); check("pushpop_status_lit", d, 32'h0000_0104);
        drain("pushpop");

        // Aborted left word
        send_half(1'b0, 24'($urandom), MSB_SLOT + 10);
        send_half(1'b1, 24'($urandom), HALF);
        exp_ferr = 1'b1;
        p = rand_pair();
        model_push(p, 1'b0);
        send_frame(p);
        check("abort_pulse_pending", 32'(exp_q.size()), 0);
        rd(2'd0, d); check("abort_status_lit", d, 32'h4000_0001);
        check_regs("abort");
        wr(2'd0, 32'h4000_0000);
        exp_ferr = 1'b0;
        drain("abort");

        // Pop while empty
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, d); check("empty_pop_lit", d, 32'h0000_0200);
        p = rand_pair();
        model_push(p, 1'b0);
        send_frame(p);
        check_regs("empty_pop");
        drain("empty_pop");

        // Reset released in the middle of a right word
        p = rand_pair();
        model_push(p, 1'b0);
        send_frame(p);
        send_half(1'b0, 24'($urandom), HALF);
        @(posedge CLK); #1;
        RESET = 1'b1;
        model_reset();
        fork
            send_half(1'b1, 24'($urandom), HALF);
            begin
                #(2 * SCLK_HP * 12);
                RESET = 1'b0;
            end
        join
        check("midreset_state", 32'(state_dbg), 32'd0);
        check_regs("midreset");
        p = rand_pair();
        model_push(p, 1'b0);
        send_frame(p);
        check("midreset_pulse_pending", 32'(exp_q.size()), 0);
        drain("midreset");

        // Random frames with random pops
        for (int k = 0; k < 8; k++) begin
            p = rand_pair();
            model_push(p, 1'b0);
            send_frame(p);
            check("rand_pulse_pending", 32'(exp_q.size()), 0);
            check_regs("rand");
            repeat ($urandom_range(0, 2)) pop_check("rand_pop");
        end
        wr(2'd0, 32'hC000_0000);
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        drain("rand_end");
        check("final_pulse_pending", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits captured per channel.
REQ-002 SHALL have parameter DEPTH, default 4, stereo-pair FIFO depth (power of 2).
REQ-003 SHALL have port CLK  input  1  system clock; all logic clocked on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SCLK  input  1  codec bit clock, asynchronous to CLK, at most CLK/8.
REQ-006 SHALL have port LRCLK  input  1  codec word select, asynchronous; low = left, high = right.
REQ-007 SHALL have port Din  input  1  codec ADC serial data, MSB first, valid on SCLK rising edge.
REQ-008 SHALL have port address  input  2  register select.
REQ-009 SHALL have port write  input  1  register write strobe, single CLK cycle.
REQ-010 SHALL have port writedata  input  32  register write data.
REQ-011 SHALL have port readdata  output  32  combinational read of the selected register.
REQ-012 SHALL have port sample_valid  output  1  one-CLK pulse per stereo pair pushed to the FIFO.

Function
REQ-013 SHALL pass SCLK, LRCLK and Din each through a 2-flop synchronizer clocked by CLK, then hold one more registered copy for edge detection.
REQ-014 SHALL treat a bit event as a detected synchronized SCLK rising edge; Din and LRCLK are sampled from the synchronized copies in that same CLK cycle.
REQ-015 SHALL run FSM states IDLE, SKIP, SHIFT, WAIT; reset state IDLE.
REQ-016 IDLE -> SKIP on a bit event where LRCLK differs from its value at the previous bit event; the channel is latched from the new LRCLK value.
REQ-017 SKIP -> SHIFT on the next bit event; the Din value of that event is discarded (I2S one-bit delay).
REQ-018 SHIFT: each bit event shifts Din into the WIDTH-bit register MSB first; after WIDTH bits -> WAIT and the word is complete.
REQ-019 WAIT: ignore Din; an LRCLK change at a bit event -> SKIP for the opposite channel.
REQ-020 An LRCLK change at a bit event while in SKIP or SHIFT SHALL discard the partial word, set sticky frame_err, and go to SKIP for the new channel.
REQ-021 A completed left word SHALL be stored in a left holding register and set left_ok; a completed right word with left_ok=1 SHALL push {left,right} into the FIFO and clear left_ok.
REQ-022 A completed right word with left_ok=0 SHALL be discarded and SHALL NOT set any error flag.
REQ-023 The push and sample_valid SHALL occur in the CLK cycle after the bit event that captures the right LSB.
REQ-024 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the pair, set sticky overrun, and still pulse sample_valid=0.
REQ-025 A simultaneous push and pop when full SHALL pop the head, then accept the push, with no overrun.
REQ-026 A pop when empty SHALL be ignored.
REQ-027 Register 0 (status) read SHALL return {overrun[31], frame_err[30], 20'b0, empty[9], full[8], count[7:0]}.
REQ-028 Register 1 read SHALL return {head_left, (32-WIDTH)'b0}; register 2 read SHALL return {head_right, (32-WIDTH)'b0}; both SHALL return 0 when the FIFO is empty.
REQ-029 Register 3 read SHALL return 0.
REQ-030 A write to register 0 with writedata[31]=1 SHALL clear overrun, and with writedata[30]=1 SHALL clear frame_err; a set event in the same cycle wins.
REQ-031 A write to register 3 (any data) SHALL pop one FIFO entry.
REQ-032 Writes to registers 1 and 2 SHALL be ignored.

Reset
REQ-033 RESET SHALL asynchronously clear the synchronizers, FSM (to IDLE), shift register, left holding register, left_ok, FIFO pointers/count, overrun, frame_err and sample_valid; readdata SHALL then read status 0x00000200.
REQ-034 The first word after reset SHALL be captured only after an LRCLK change is observed (REQ-016); a frame in progress at reset release SHALL be ignored.

Verification
REQ-035 Reset, SCLK = CLK/16, 64-bit frames with left=0xABCDEF and right=0x123456 -> one sample_valid pulse; reg1=0xABCDEF00, reg2=0x12345600, status count=1.
REQ-036 Send 5 frames with no pops (DEPTH=4) -> count=4, full=1, overrun=1; the head is the frame-1 pair; write reg0 with writedata=0x80000000 -> overrun=0.
REQ-037 Toggle LRCLK after 10 bits of a left word -> frame_err=1, no push; the next complete frame is pushed correctly.
REQ-038 Release RESET mid-right-word, then send a full frame -> exactly one pair is pushed, equal to the full frame.
REQ-039 FIFO full with a right LSB arriving in the same cycle as a write to reg3 -> overrun stays 0, count stays 4, and the new pair becomes the tail.
REQ-040 Write reg3 with the FIFO empty -> count=0, empty=1, no pointer corruption; the next frame reads back correctly.
